stack_unit: RTL

Sequencer for PUSH/POP/CALL/RET in the 8-bit ELC3030 processor core. It accepts one stack operation at a time and reads the current stack pointer (R3, reset 0xFF) from the register file. It performs the data-memory access through a req/ack handshake. It then drives the register file's single write port to update SP and, for POP, the destination register; for RET it loads the PC instead.

---
 rtl/stack_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
// PUSH/POP/CALL/RET sequencer for the 8-bit ELC3030 core. It takes one stack
// operation at a time and does the data-memory access over a req/ack
// handshake. It then uses the register file's single write port to update SP
// (R3) and, for POP, the destination register. For RET it loads the PC
// instead. SP points to the next free slot.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   op_valid/op_ready          operation handshake (ready only in IDLE)
//   op_kind                    00 PUSH, 01 POP, 10 CALL, 11 RET
//   op_data, op_rd             PUSH/CALL data, POP destination register
//   sp_in                      current SP from the register file
//   mem_req/we/addr/wdata      memory request, held until mem_ack
//   mem_rdata, mem_ack         memory response
//   rf_wr_en/addr/data         register file write port
//   pc_load, pc_value          one-cycle PC load at RET completion
//   busy                       ~op_ready
//   stack_fault                sticky bounds fault
//
// Build option: define STACK_BOUNDS_CHECK_EN to reject PUSH/CALL at SP=0x00
// and POP/RET at SP=0xFF. These operations set the sticky stack_fault. When
// the macro is undefined, SP wraps and stack_fault is tied low.
// -----------------------------------------------------------------------------
module stack_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [1:0] op_kind,
  input  logic [7:0] op_data,
  input  logic [1:0] op_rd,
  input  logic [7:0] sp_in,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       rf_wr_en,
  output logic [1:0] rf_wr_addr,
  output logic [7:0] rf_wr_data,
  output logic       pc_load,
  output logic [7:0] pc_value,
  output logic       busy,
  output logic       stack_fault
);

  typedef enum logic [2:0] {IDLE, MEM, SP_WB, REG_WB, PC_WB} state_t;

  state_t     state;
  logic [7:0] sp_reg;
  logic [7:0] data_reg;   // op_data at accept, replaced by mem_rdata on reads
  logic [1:0] kind_reg;
  logic [1:0] rd_reg;
  logic       op_fault;

  // op_kind[0] separates the two directions: 0 = PUSH/CALL, 1 = POP/RET.
`ifdef STACK_BOUNDS_CHECK_EN
  logic fault_reg;
  assign op_fault    = op_kind[0] ? (sp_in == 8'hFF) : (sp_in == 8'h00);
  assign stack_fault = fault_reg;
`else
  assign op_fault    = 1'b0;
  assign stack_fault = 1'b0;
`endif

  assign busy = ~op_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sp_reg     <= 8'h00;
      data_reg   <= 8'h00;
      kind_reg   <= 2'b00;
      rd_reg     <= 2'b00;
      op_ready   <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 8'h00;
      mem_wdata  <= 8'h00;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= 2'b00;
      rf_wr_data <= 8'h00;
      pc_load    <= 1'b0;
      pc_value   <= 8'h00;
`ifdef STACK_BOUNDS_CHECK_EN
      fault_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            kind_reg <= op_kind;
            rd_reg   <= op_rd;
            sp_reg   <= sp_in;
            data_reg <= op_data;
            // A faulting op is accepted and then dropped, so it stays in IDLE.
            if (!op_fault) begin
              state     <= MEM;
              op_ready  <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= ~op_kind[0];
              mem_addr  <= op_kind[0] ? sp_in + 8'd1 : sp_in;
              mem_wdata <= op_kind[0] ? 8'h00 : op_data;
            end
`ifdef STACK_BOUNDS_CHECK_EN
            if (op_fault) fault_reg <= 1'b1;
`endif
          end
        end

        MEM: begin
          if (mem_ack) begin
            if (kind_reg[0]) data_reg <= mem_rdata;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 8'h00;
            mem_wdata  <= 8'h00;
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= 2'd3;
            rf_wr_data <= kind_reg[0] ? sp_reg + 8'd1 : sp_reg - 8'd1;
            state      <= SP_WB;
          end
        end

        SP_WB: begin
          case (kind_reg)
            2'b01: begin  // POP: second write to the destination register
              rf_wr_addr <= rd_reg;
              rf_wr_data <= data_reg;
              state      <= REG_WB;
            end
            2'b11: begin  // RET: hand the popped address to the PC
              rf_wr_en   <= 1'b0;
              rf_wr_addr <= 2'b00;
              rf_wr_data <= 8'h00;
              pc_load    <= 1'b1;
              pc_value   <= data_reg;
              state      <= PC_WB;
            end
            default: begin  // PUSH/CALL are complete
              rf_wr_en   <= 1'b0;
              rf_wr_addr <= 2'b00;
              rf_wr_data <= 8'h00;
              op_ready   <= 1'b1;
              state      <= IDLE;
            end
          endcase
        end

        REG_WB: begin
          rf_wr_en   <= 1'b0;
          rf_wr_addr <= 2'b00;
          rf_wr_data <= 8'h00;
          op_ready   <= 1'b1;
          state      <= IDLE;
        end

        PC_WB: begin
          pc_load  <= 1'b0;
          pc_value <= 8'h00;
          op_ready <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          op_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
